sdram_init_sequencer: RTL and testbench
=======================================

// Module: sdram_init_sequencer
// PURPOSE
//   Drives the SDRAM power-up initialisation sequence: power-up wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE REGISTER.
//   Acts as the master of the shared wait-counter interface. It loads period and pulses timer_reset, then waits on count_finish.
//   Sits between the top-level reset/start logic and the SDRAM command mux. The mux passes cmd/addr/ba/cke to the pins until init_done.
// PARAMETERS
//   SIZE       16      width of period output; must match the wait counter
//   ADDR_W     13      SDRAM address width
//   T_POWERUP  20000   cycles from power-up start to PRECHARGE (200us @100MHz)
//   T_RP       3       cycles PRECHARGE -> next cmd (>=3, elaboration error otherwise)
//   T_RFC      7       cycles AUTO REFRESH -> next cmd (>=3)
//   T_MRD      3       cycles LOAD MODE -> init_done (>=3)
//   N_REFRESH  2       number of AUTO REFRESH commands (>=1)
//   MODE_REG   13'h032 value driven on addr during LOAD MODE (CL3, BL4, sequential)
// PORTS
//   CLK          in   1       system clock
//   RST          in   1       async reset, active-high
//   start        in   1       1-cycle request to begin initialisation
//   period       out  SIZE    wait length loaded into counter
//   timer_reset  out  1       clears counter; high exactly in command cycles
//   count_finish in   1       counter reached period
//   cke          out  1       SDRAM clock enable
//   cmd          out  4       {CS_n,RAS_n,CAS_n,WE_n}
//   addr         out  ADDR_W  SDRAM address
//   ba           out  2       bank address
//   busy         out  1       sequence in progress
//   init_done    out  1       sequence complete, sticky until RST
// BEHAVIOUR
//   Reset values: state IDLE, cke=0, cmd=INHIBIT 4'b1111, addr=0, ba=0, period=0, timer_reset=0, busy=0, init_done=0, ref_cnt=0.
//   All outputs are registered. Each output changes only on the CLK edge that enters the state it belongs to.
//   Encodings: NOP 4'b0111, PRECHARGE 4'b0010, AUTO_REFRESH 4'b0001, LOAD_MODE 4'b0000.
//   States: IDLE, PWR_START, PWR_WAIT, PRE, WAIT_RP, REF, WAIT_RFC, LMR, WAIT_MRD, DONE.
//   IDLE: start=1 -> PWR_START. Otherwise stay in IDLE.
//   Command states (PWR_START, PRE, REF, LMR): exactly 1 cycle each.
//     - timer_reset=1; period=T_x-2; cmd as named (PWR_START drives NOP).
//     - Always go to the matching WAIT state. count_finish is ignored in command states.
//   WAIT states: timer_reset=0, cmd=NOP. Leave on the first cycle with count_finish=1.
//   Timing rule: the next command is issued exactly T_x cycles after the previous command cycle.
//   PRE: addr[10]=1 (all banks), other addr bits 0. LMR: addr=MODE_REG, ba=0.
//   WAIT_RFC exit: ref_cnt==N_REFRESH-1 -> LMR and clear ref_cnt; else ref_cnt+1 -> REF.
//   WAIT_MRD exit -> DONE. In DONE: init_done=1, busy=0, cmd=NOP, cke=1.
//   cke=1 and busy=1 in every state other than IDLE; DONE has busy=0.
//   start is ignored outside IDLE, except as stated under CONFIGURATION.
//   RST mid-sequence: everything returns to reset values immediately (async). A fresh start is needed afterwards.
//   Stuck counter (count_finish never rises): stays in the WAIT state. No internal timeout.
// CONFIGURATION
//   SDRAM_INIT_REINIT_EN defined: start=1 in DONE -> PWR_START. init_done drops on that edge; full sequence reruns.
//   Not defined: start in DONE is ignored; init_done is sticky until RST.
// STRUCTURE
//   sdram_pkg: command encodings, state localparams, PRECHARGE_ALL_BIT=10.
//   One sub-module, sdram_cmd_out_reg: registers cmd/addr/ba/cke from decoded state, reset to INHIBIT/0.
//   The wait counter is external. Its width must equal SIZE.
// TESTING (bench counter model; T_POWERUP=10,T_RP=3,T_RFC=5,T_MRD=3,N_REFRESH=2)
//   1. start pulse at cycle 0 -> cmds at cycles 1(NOP+treset),11(PRE),14(REF),19(REF),24(LMR); init_done=1 at cycle 27.
//   2. Per command cycle -> timer_reset=1 for exactly 1 cycle; period=8,1,3,3,1 respectively.
//   3. RST asserted during WAIT_RFC -> outputs at reset values same cycle; new start reruns the full 27-cycle sequence.
//   4. start held high throughout / repulsed mid-sequence -> sequence timing unchanged; no restart.
//   5. start in DONE: without macro init_done stays 1; with SDRAM_INIT_REINIT_EN init_done=0 next cycle, PRE 10 cycles later.
//   6. count_finish forced high during command cycles -> ignored; forced low -> FSM holds in WAIT with cmd=NOP.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM power-up initialisation sequencer.
// Optional feature macro (see top): SDRAM_INIT_REINIT_EN.
package sdram_pkg;

    // {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] CMD_INHIBIT      = 4'b1111;
    localparam logic [3:0] CMD_NOP          = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;

    localparam int PRECHARGE_ALL_BIT = 10;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_PWR_START = 4'd1,
        ST_PWR_WAIT  = 4'd2,
        ST_PRE       = 4'd3,
        ST_WAIT_RP   = 4'd4,
        ST_REF       = 4'd5,
        ST_WAIT_RFC  = 4'd6,
        ST_LMR       = 4'd7,
        ST_WAIT_MRD  = 4'd8,
        ST_DONE      = 4'd9
    } state_e;

    // Command states last one cycle and restart the external wait counter.
    function automatic logic is_cmd_state(input state_e s);
        return (s == ST_PWR_START) || (s == ST_PRE) || (s == ST_REF) || (s == ST_LMR);
    endfunction

endpackage

// File: rtl/sdram_cmd_out_reg.sv
// Registered SDRAM pin driver: decodes the next FSM state into cmd/addr/ba/cke
// so the pins change on the same edge that enters the state.
module sdram_cmd_out_reg
    import sdram_pkg::*;
#(
    parameter int                ADDR_W   = 13,
    parameter logic [ADDR_W-1:0] MODE_REG = ADDR_W'(13'h032)
) (
    input  logic              CLK,
    input  logic              RST,
    input  state_e            state_d,
    output logic [3:0]        cmd,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        ba,
    output logic              cke
);

    logic [3:0]        cmd_d,  cmd_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [1:0]        ba_d,   ba_q;
    logic              cke_d,  cke_q;

    always_comb begin
        cmd_d  = CMD_NOP;
        addr_d = '0;
        ba_d   = 2'b00;
        cke_d  = 1'b1;
        case (state_d)
            ST_IDLE: begin
                cmd_d = CMD_INHIBIT;
                cke_d = 1'b0;
            end
            ST_PRE: begin
                cmd_d                    = CMD_PRECHARGE;
                addr_d[PRECHARGE_ALL_BIT] = 1'b1;
            end
            ST_REF:  cmd_d = CMD_AUTO_REFRESH;
            ST_LMR: begin
                cmd_d  = CMD_LOAD_MODE;
                addr_d = MODE_REG;
            end
            default: cmd_d = CMD_NOP;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cmd_q  <= CMD_INHIBIT;
            addr_q <= '0;
            ba_q   <= 2'b00;
            cke_q  <= 1'b0;
        end else begin
            cmd_q  <= cmd_d;
            addr_q <= addr_d;
            ba_q   <= ba_d;
            cke_q  <= cke_d;
        end
    end

    assign cmd  = cmd_q;
    assign addr = addr_q;
    assign ba   = ba_q;
    assign cke  = cke_q;

endmodule

// File: rtl/sdram_init_sequencer.sv
// SDRAM power-up init: wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE.
// Define SDRAM_INIT_REINIT_EN to let start in DONE rerun the whole sequence.
module sdram_init_sequencer
    import sdram_pkg::*;
#(
    parameter int                SIZE      = 16,
    parameter int                ADDR_W    = 13,
    parameter int                T_POWERUP = 20000,
    parameter int                T_RP      = 3,
    parameter int                T_RFC     = 7,
    parameter int                T_MRD     = 3,
    parameter int                N_REFRESH = 2,
    parameter logic [ADDR_W-1:0] MODE_REG  = ADDR_W'(13'h032)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic [SIZE-1:0]   period,
    output logic              timer_reset,
    input  logic              count_finish,
    output logic              cke,
    output logic [3:0]        cmd,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        ba,
    output logic              busy,
    output logic              init_done
);

    localparam int RC_W = (N_REFRESH > 1) ? $clog2(N_REFRESH) : 1;

    if (T_POWERUP < 3 || T_RP < 3 || T_RFC < 3 || T_MRD < 3 || N_REFRESH < 1) begin : g_param_err
        $error("sdram_init_sequencer: timing parameters must be >= 3 and N_REFRESH >= 1");
    end

    state_e            state_d, state_q;
    logic [RC_W-1:0]   ref_cnt_d, ref_cnt_q;
    logic [SIZE-1:0]   period_d, period_q;
    logic              timer_reset_d, timer_reset_q;
    logic              busy_d, busy_q;
    logic              init_done_d, init_done_q;

    always_comb begin
        state_d   = state_q;
        ref_cnt_d = ref_cnt_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = ST_PWR_START;
            ST_PWR_START: state_d = ST_PWR_WAIT;
            ST_PWR_WAIT:  if (count_finish) state_d = ST_PRE;
            ST_PRE:       state_d = ST_WAIT_RP;
            ST_WAIT_RP:   if (count_finish) state_d = ST_REF;
            ST_REF:       state_d = ST_WAIT_RFC;
            ST_WAIT_RFC: begin
                if (count_finish) begin
                    if (ref_cnt_q == RC_W'(N_REFRESH - 1)) begin
                        state_d   = ST_LMR;
                        ref_cnt_d = '0;
                    end else begin
                        state_d   = ST_REF;
                        ref_cnt_d = ref_cnt_q + RC_W'(1);
                    end
                end
            end
            ST_LMR:       state_d = ST_WAIT_MRD;
            ST_WAIT_MRD:  if (count_finish) state_d = ST_DONE;
`ifdef SDRAM_INIT_REINIT_EN
            ST_DONE:      if (start) state_d = ST_PWR_START;
`else
            ST_DONE:      state_d = ST_DONE;
`endif
            default:      state_d = ST_IDLE;
        endcase
    end

    // Outputs decode state_d so they land on the edge that enters the state.
    // period holds between commands so the counter compare stays stable.
    always_comb begin
        period_d      = period_q;
        timer_reset_d = is_cmd_state(state_d);
        busy_d        = (state_d != ST_IDLE) && (state_d != ST_DONE);
        init_done_d   = (state_d == ST_DONE);
        case (state_d)
            ST_PWR_START: period_d = SIZE'(T_POWERUP - 2);
            ST_PRE:       period_d = SIZE'(T_RP - 2);
            ST_REF:       period_d = SIZE'(T_RFC - 2);
            ST_LMR:       period_d = SIZE'(T_MRD - 2);
            default:      period_d = period_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            ref_cnt_q     <= '0;
            period_q      <= '0;
            timer_reset_q <= 1'b0;
            busy_q        <= 1'b0;
            init_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ref_cnt_q     <= ref_cnt_d;
            period_q      <= period_d;
            timer_reset_q <= timer_reset_d;
            busy_q        <= busy_d;
            init_done_q   <= init_done_d;
        end
    end

    sdram_cmd_out_reg #(
        .ADDR_W   (ADDR_W),
        .MODE_REG (MODE_REG)
    ) u_cmd_out (
        .CLK     (CLK),
        .RST     (RST),
        .state_d (state_d),
        .cmd     (cmd),
        .addr    (addr),
        .ba      (ba),
        .cke     (cke)
    );

    assign period      = period_q;
    assign timer_reset = timer_reset_q;
    assign busy        = busy_q;
    assign init_done   = init_done_q;

endmodule

// File: tb/tb_sdram_init_sequencer.sv
// Randomized bench for sdram_init_sequencer: external wait counter plus a
// command-schedule reference model computed from the timing parameters.
module tb_sdram_init_sequencer;

    localparam int SIZE = 16, ADDR_W = 13;
    localparam int TPU = 10, TRP = 3, TRFC = 5, TMRD = 3, NREF = 2;
    localparam logic [ADDR_W-1:0] MODE = 13'h032;
    localparam logic [3:0] C_INH = 4'b1111, C_NOP = 4'b0111, C_PRE = 4'b0010,
                           C_REF = 4'b0001, C_LMR = 4'b0000;

    logic              CLK = 1'b0, RST, start, count_finish, timer_reset;
    logic              cke, busy, init_done;
    logic [SIZE-1:0]   period;
    logic [3:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        ba;

    logic              force_hi, force_lo;
    logic [SIZE-1:0]   cnt_q;

    int n_chk = 0, n_fail = 0;
    int ev_cyc[$], ev_cmd[$], ev_per[$];
    int done_k;

    sdram_init_sequencer #(
        .SIZE(SIZE), .ADDR_W(ADDR_W), .T_POWERUP(TPU), .T_RP(TRP),
        .T_RFC(TRFC), .T_MRD(TMRD), .N_REFRESH(NREF), .MODE_REG(MODE)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .period(period),
        .timer_reset(timer_reset), .count_finish(count_finish), .cke(cke),
        .cmd(cmd), .addr(addr), .ba(ba), .busy(busy), .init_done(init_done)
    );

    always #5 CLK = ~CLK;

    // External wait counter: cleared by timer_reset, flags when count == period.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)              cnt_q <= '0;
        else if (timer_reset) cnt_q <= '0;
        else                  cnt_q <= cnt_q + 1'b1;
    end
    assign count_finish = force_lo ? 1'b0 : ((cnt_q == period) || (force_hi && timer_reset));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Command k cycles after the start cycle; each command follows the previous by T_x.
    task automatic build_model();
        int c;
        c = 1;
        ev_cyc.push_back(c); ev_cmd.push_back(C_NOP); ev_per.push_back(TPU - 2);  c += TPU;
        ev_cyc.push_back(c); ev_cmd.push_back(C_PRE); ev_per.push_back(TRP - 2);  c += TRP;
        for (int i = 0; i < NREF; i++) begin
            ev_cyc.push_back(c); ev_cmd.push_back(C_REF); ev_per.push_back(TRFC - 2); c += TRFC;
        end
        ev_cyc.push_back(c); ev_cmd.push_back(C_LMR); ev_per.push_back(TMRD - 2); c += TMRD;
        done_k = c;
    endtask

    task automatic check_cycle(input int k);
        int idx;
        idx = -1;
        foreach (ev_cyc[i]) if (ev_cyc[i] == k) idx = i;
        chk("cmd", 32'(cmd), (idx >= 0) ? 32'(ev_cmd[idx]) : 32'(C_NOP));
        chk("timer_reset", 32'(timer_reset), 32'(idx >= 0));
        chk("busy", 32'(busy), 32'(k < done_k));
        chk("init_done", 32'(init_done), 32'(k >= done_k));
        chk("cke", 32'(cke), 32'd1);
        if (idx >= 0) begin
            chk("period", 32'(period), 32'(ev_per[idx]));
            if (ev_cmd[idx] == C_PRE) chk("pre_addr", 32'(addr), 32'h400);
            if (ev_cmd[idx] == C_LMR) begin
                chk("lmr_addr", 32'(addr), 32'(MODE));
                chk("lmr_ba", 32'(ba), 32'd0);
            end
        end
    endtask

    // Called at a negedge; start goes high for the edge that begins cycle 1.
    task automatic run_seq(input int stop_k, input bit noise);
        start = 1'b1;
        for (int k = 1; k <= stop_k; k++) begin
            @(negedge CLK);
            check_cycle(k);
            start = (noise && k < done_k) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_cmd", 32'(cmd), 32'(C_INH));
        chk("rst_cke", 32'(cke), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_ba", 32'(ba), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_treset", 32'(timer_reset), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        check_reset_vals();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic start_in_done();
`ifdef SDRAM_INIT_REINIT_EN
        run_seq(done_k + 2, 1'b0);
`else
        start = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge CLK);
            start = 1'b0;
            chk("sticky_done", 32'(init_done), 32'd1);
            chk("sticky_busy", 32'(busy), 32'd0);
            chk("sticky_cmd", 32'(cmd), 32'(C_NOP));
            chk("sticky_treset", 32'(timer_reset), 32'd0);
        end
`endif
    endtask

    initial begin
        int k_stop, k_stall;
        RST = 1'b1; start = 1'b0; force_hi = 1'b0; force_lo = 1'b0;
        build_model();
        repeat (3) @(negedge CLK);
        check_reset_vals();
        RST = 1'b0;
        @(negedge CLK);

        // Nominal runs with random idle gaps and random start noise mid-sequence
        for (int it = 0; it < 3; it++) begin
            repeat ($urandom_range(0, 5)) @(negedge CLK);
            chk("idle_cmd", 32'(cmd), 32'(C_INH));
            run_seq(done_k + 2, it != 0);
            start_in_done();
            do_reset();
        end

        // Reset during a random WAIT_RFC cycle, then a clean full rerun
        k_stop = ev_cyc[2 + $urandom_range(0, NREF - 1)] + 1 + $urandom_range(0, TRFC - 2);
        run_seq(k_stop, 1'b1);
        do_reset();
        run_seq(done_k + 2, 1'b0);
        do_reset();

        // count_finish asserted during command cycles must not shorten anything
        force_hi = 1'b1;
        run_seq(done_k + 2, 1'b1);
        force_hi = 1'b0;
        do_reset();

        // Stuck counter: FSM parks in a WAIT state with NOP
        k_stall = $urandom_range(1, done_k - 1);
        run_seq(k_stall, 1'b0);
        force_lo = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge CLK);
            chk("stall_cmd", 32'(cmd), 32'(C_NOP));
            chk("stall_treset", 32'(timer_reset), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_done", 32'(init_done), 32'd0);
        end
        force_lo = 1'b0;
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
